// File: rtl/idli_pkg.sv
// idli_pkg: shared ALU opcode, register-name types and nibble-serial word constants.
package idli_pkg;
  typedef logic [2:0] greg_t;
  localparam greg_t GREG_PC = 3'd7;
  localparam int ALU_NIBBLES = 4;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_ANDN = 3'd5,
    ALU_EQ   = 3'd6,
    ALU_LTU  = 3'd7
  } alu_op_t;
endpackage

// File: rtl/idli_alu_if.sv
// idli_alu_if: decode/GRF <-> ALU bundle; master = ALU (start/op/dest/read nibbles in, write ports/status out), slave = decode+GRF side.
interface idli_alu_if;
  import idli_pkg::*;
  logic start;
  alu_op_t op;
  greg_t dest;
  logic pc_inc;
  logic [3:0] b_data;
  logic [3:0] c_data;
  logic [3:0] pc_rd;
  greg_t wr_a;
  logic a_vld;
  logic [3:0] a_data;
  logic pc_vld;
  logic [3:0] pc_wr;
  logic busy;
  logic done;
  logic flag;
  modport master (
    input  start, op, dest, pc_inc, b_data, c_data, pc_rd,
    output wr_a, a_vld, a_data, pc_vld, pc_wr, busy, done, flag
  );
  modport slave (
    output start, op, dest, pc_inc, b_data, c_data, pc_rd,
    input  wr_a, a_vld, a_data, pc_vld, pc_wr, busy, done, flag
  );
endinterface

// File: rtl/idli_alu_nadd_m.sv
// idli_alu_nadd_m: combinational nibble adder; ports a,b (4b), cin in; sum (4b), cout out.
module idli_alu_nadd_m (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/idli_alu_m.sv
// idli_alu_m: nibble-serial ALU; ports i_alu_gck clock, i_alu_rst async reset, alu (idli_alu_if.master) for decode/GRF traffic.
module idli_alu_m
  import idli_pkg::*;
(
  input logic        i_alu_gck,
  input logic        i_alu_rst,
  idli_alu_if.master alu
);
  logic [1:0] ctr_q;
  logic busy_q, carry_q, pc_carry_q, zero_q, flag_q, done_q, pc_inc_q;
  alu_op_t op_q;
  greg_t dest_q;
  logic go, last, b2b, active, first, pc_inc, cin, cout, pc_cout, zero_c;
  alu_op_t op;
  logic [3:0] c_eff, sum;
  assign go = alu.start & ~busy_q;
  assign last = busy_q & (ctr_q == 2'(ALU_NIBBLES - 1));
  // A start during the final nibble latches the next op; its nibble 0 follows with ctr_q=0 and busy held.
  assign b2b = alu.start & last;
  assign active = go | busy_q;
  assign first = go | (busy_q & (ctr_q == 2'd0));
  assign op = go ? alu.op : op_q;
  assign pc_inc = go ? alu.pc_inc : pc_inc_q;
  assign alu.wr_a = go ? alu.dest : dest_q;
  // Nibble 0 seeds carries from the op itself, so nothing chains across ops.
  assign cin = first ? (op != ALU_ADD) : carry_q;
  assign c_eff = (op == ALU_ADD) ? alu.c_data : ~alu.c_data;
  assign zero_c = (alu.b_data == alu.c_data) & (first | zero_q);
  idli_alu_nadd_m u_alu (.a(alu.b_data), .b(c_eff), .cin, .sum, .cout);
  idli_alu_nadd_m u_pc (.a(alu.pc_rd), .b(4'h0), .cin(first | pc_carry_q), .sum(alu.pc_wr), .cout(pc_cout));
  assign alu.a_data = (op == ALU_AND)  ? alu.b_data & alu.c_data :
                      (op == ALU_OR)   ? alu.b_data | alu.c_data :
                      (op == ALU_XOR)  ? alu.b_data ^ alu.c_data :
                      (op == ALU_ANDN) ? alu.b_data & ~alu.c_data : sum;
  // Write strobes drop the instant reset rises, even with start held high.
  assign alu.a_vld = ~i_alu_rst & active & (op < ALU_EQ);
  assign alu.pc_vld = ~i_alu_rst & active & pc_inc;
  assign alu.busy = busy_q;
  assign alu.done = done_q;
  assign alu.flag = flag_q;
  always_ff @(posedge i_alu_gck or posedge i_alu_rst)
    if (i_alu_rst) begin
      ctr_q <= '0;
      busy_q <= 1'b0;
      carry_q <= 1'b0;
      pc_carry_q <= 1'b0;
      zero_q <= 1'b0;
      flag_q <= 1'b0;
      done_q <= 1'b0;
      pc_inc_q <= 1'b0;
      op_q <= ALU_ADD;
      dest_q <= '0;
    end else begin
      if (last) begin
        ctr_q <= '0;
        busy_q <= b2b;
      end else if (go) begin
        ctr_q <= 2'd1;
        busy_q <= 1'b1;
      end else if (busy_q) ctr_q <= ctr_q + 2'd1;
      if (go | b2b) begin
        op_q <= alu.op;
        dest_q <= alu.dest;
        pc_inc_q <= alu.pc_inc;
      end
      carry_q <= cout;
      pc_carry_q <= pc_cout;
      zero_q <= zero_c;
      done_q <= last;
      if (last)
        flag_q <= (op == ALU_ADD || op == ALU_SUB) ? cout :
                  (op == ALU_EQ)  ? zero_c :
                  (op == ALU_LTU) ? ~cout : flag_q;
    end
endmodule

// File: tb/tb_idli_alu_m.sv
// tb_idli_alu_m: drives GRF-style nibbles into idli_alu_m and scoreboards per-cycle outputs.
module tb_idli_alu_m;
  import idli_pkg::*;
  typedef struct packed {
    logic a_vld;
    logic [3:0] a_data;
    greg_t a;
    logic pc_vld;
    logic [3:0] pc_data;
    logic busy;
    logic done;
    logic flag;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int n_assert = 0;
  int n_fail = 0;
  string tag = "reset";
  exp_t sb[$];
  logic m_flag = 1'b0;
  logic m_done = 1'b0;
  idli_alu_if ifc ();
  idli_alu_m dut (.i_alu_gck(clk), .i_alu_rst(rst), .alu(ifc.master));
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic av, input logic [3:0] ad, input greg_t a, input logic pv,
                              input logic [3:0] pd, input logic b, input logic d, input logic f);
    exp_t e;
    e.a_vld = av;
    e.a_data = ad;
    e.a = a;
    e.pc_vld = pv;
    e.pc_data = pd;
    e.busy = b;
    e.done = d;
    e.flag = f;
    return e;
  endfunction
  task automatic chk(input string n, input logic [3:0] got, input logic [3:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %h expected %h", tag, n, got, want);
    end
  endtask
  task automatic check();
    exp_t e;
    e = sb.pop_front();
    chk("a_vld", 4'(ifc.a_vld), 4'(e.a_vld));
    if (e.a_vld) begin
      chk("a_data", ifc.a_data, e.a_data);
      chk("a", 4'(ifc.wr_a), 4'(e.a));
    end
    chk("pc_vld", 4'(ifc.pc_vld), 4'(e.pc_vld));
    if (e.pc_vld) chk("pc_data", ifc.pc_wr, e.pc_data);
    chk("busy", 4'(ifc.busy), 4'(e.busy));
    chk("done", 4'(ifc.done), 4'(e.done));
    chk("flag", 4'(ifc.flag), 4'(e.flag));
  endtask
  task automatic step(input logic st, input alu_op_t op, input greg_t d, input logic pi,
                      input logic [3:0] b, input logic [3:0] c, input logic [3:0] pc, input exp_t e);
    @(negedge clk);
    ifc.start = st;
    ifc.op = op;
    ifc.dest = d;
    ifc.pc_inc = pi;
    ifc.b_data = b;
    ifc.c_data = c;
    ifc.pc_rd = pc;
    sb.push_back(e);
    #2;
    check();
  endtask
  task automatic idle();
    step(1'b0, ALU_ADD, 3'd0, 1'b0, 4'h0, 4'h0, 4'h0, mk(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 1'b0, m_done, m_flag));
    m_done = 1'b0;
  endtask
  task automatic do_op(input string t, input alu_op_t op, input greg_t d, input logic pi,
                       input logic [15:0] bw, input logic [15:0] cw, input logic [15:0] pcw,
                       input logic from_chain, input logic chain, input alu_op_t nop, input greg_t nd,
                       input logic npi, input logic junk, input int n);
    logic [15:0] res, pcn;
    logic nf;
    tag = t;
    pcn = pcw + 16'd1;
    res = (op == ALU_ADD) ? bw + cw : (op == ALU_SUB) ? bw - cw : (op == ALU_AND) ? bw & cw :
          (op == ALU_OR) ? bw | cw : (op == ALU_XOR) ? bw ^ cw : (op == ALU_ANDN) ? bw & ~cw : 16'h0;
    nf = (op == ALU_ADD) ? ({1'b0, bw} + {1'b0, cw} > 17'hFFFF) : (op == ALU_SUB) ? (bw >= cw) :
         (op == ALU_EQ) ? (bw == cw) : (op == ALU_LTU) ? (bw < cw) : m_flag;
    for (int k = 0; k < n; k++) begin
      logic st, p;
      alu_op_t o;
      greg_t dd;
      st = (k == 0 && !from_chain) || (k == 3 && chain) || (k == 1 && junk);
      o = (k == 3 && chain) ? nop : (k == 1 && junk) ? ALU_XOR : op;
      dd = (k == 3 && chain) ? nd : (k == 1 && junk) ? 3'd6 : d;
      p = (k == 3 && chain) ? npi : (k == 1 && junk) ? ~pi : pi;
      step(st, o, dd, p, bw[4*k +: 4], cw[4*k +: 4], pcw[4*k +: 4],
           mk(op < ALU_EQ, res[4*k +: 4], d, pi, pcn[4*k +: 4], (k == 0) ? from_chain : 1'b1,
              (k == 0) ? m_done : 1'b0, m_flag));
      if (k == 0) m_done = 1'b0;
    end
    if (n == ALU_NIBBLES) begin
      m_flag = nf;
      m_done = 1'b1;
    end
  endtask
  initial begin
    rst = 1'b1;
    ifc.start = 1'b1;
    ifc.op = ALU_ADD;
    ifc.dest = 3'd1;
    ifc.pc_inc = 1'b1;
    ifc.b_data = 4'h0;
    ifc.c_data = 4'h0;
    ifc.pc_rd = 4'h0;
    #3;
    sb.push_back(mk(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
    check();
    @(negedge clk);
    rst = 1'b0;
    ifc.start = 1'b0;
    tag = "idle";
    idle();
    do_op("add", ALU_ADD, 3'd3, 1'b0, 16'h1234, 16'h0FFF, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    tag = "add_done";
    idle();
    do_op("sub", ALU_SUB, 3'd1, 1'b0, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    do_op("ltu", ALU_LTU, 3'd1, 1'b0, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    do_op("eq_same", ALU_EQ, 3'd2, 1'b0, 16'hABCD, 16'hABCD, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    do_op("eq_diff", ALU_EQ, 3'd2, 1'b0, 16'hABCD, 16'hABCE, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    tag = "eq_done";
    idle();
    do_op("b2b_old", ALU_LTU, 3'd2, 1'b1, 16'h0001, 16'h0002, 16'h0010, 1'b0, 1'b1, ALU_SUB, GREG_PC, 1'b1, 1'b0, 4);
    do_op("b2b_new", ALU_SUB, GREG_PC, 1'b1, 16'h0005, 16'h0003, 16'hFFFF, 1'b1, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    tag = "b2b_done";
    idle();
    do_op("junk", ALU_AND, 3'd5, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b1, 4);
    tag = "junk_done";
    idle();
    idle();
    do_op("xor_andn", ALU_ANDN, 3'd4, 1'b0, 16'hFF00, 16'h0F0F, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    do_op("set_flag", ALU_EQ, 3'd1, 1'b0, 16'h5555, 16'h5555, 16'h0, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    do_op("rst_mid", ALU_ADD, 3'd3, 1'b1, 16'h1111, 16'h2222, 16'h0040, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 3);
    rst = 1'b1;
    #1;
    tag = "rst_async";
    sb.push_back(mk(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
    check();
    @(negedge clk);
    rst = 1'b0;
    m_flag = 1'b0;
    m_done = 1'b0;
    do_op("after_rst", ALU_OR, 3'd6, 1'b1, 16'h00F0, 16'h0F00, 16'h1234, 1'b0, 1'b0, ALU_ADD, 3'd0, 1'b0, 1'b0, 4);
    tag = "after_rst_done";
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
